palette_writer: RTL and testbench
=================================

// Module: palette_writer
// PURPOSE
//   Write-side companion to the async palette/tile ROMs: loads WORD_SIZE-bit words
//   into a palette RAM from a byte stream (host loader/UART), so palettes change at
//   run time. Packs bytes little-endian into words and issues single-cycle writes
//   at auto-incrementing addresses. Sits between the byte source and the RAM write port.
// PARAMETERS
//   MEM_SIZE   4096  number of words in target memory; address wraps at MEM_SIZE-1
//   WORD_SIZE  20    bits per memory word
//   ADDR_SIZE  16    width of address and count ports
//   (localparam BPW = (WORD_SIZE+7)/8 bytes per word; 3 at defaults)
// PORTS
//   clk            in   1          system clock, all state on rising edge
//   reset          in   1          asynchronous, active-high reset
//   start_i        in   1          1-cycle pulse: begin load (honoured only in IDLE)
//   start_addr_i   in   ADDR_SIZE  first word address, sampled with start_i
//   count_i        in   ADDR_SIZE  number of words to load, sampled with start_i
//   byte_i         in   8          stream byte
//   byte_valid_i   in   1          byte_i valid
//   byte_ready_o   out  1          writer accepts byte this cycle
//   wr_en_o        out  1          RAM write strobe, 1 cycle per word
//   wr_addr_o      out  ADDR_SIZE  RAM write address
//   wr_data_o      out  WORD_SIZE  RAM write data
//   busy_o         out  1          load in progress (state != IDLE)
//   done_o         out  1          1-cycle pulse at end of load
//   error_o        out  1          checksum mismatch, valid with done_o
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; address, remaining count, assembly reg cleared.
//     Reset mid-load abandons the load; no partial word is written.
//   - States: IDLE -> COLLECT -> WRITE -> (COLLECT | [CHECK] | DONE) -> IDLE.
//   - IDLE: start_i=1 latches start_addr_i (taken modulo MEM_SIZE) and count_i.
//     count_i==0 -> DONE next cycle, no writes. start_i while busy_o=1 is ignored.
//   - COLLECT: byte_ready_o=1; byte accepted when byte_valid_i&&byte_ready_o.
//     Byte k (0..BPW-1) fills bits [8k+7:8k]; bits above WORD_SIZE-1 discarded.
//     After byte BPW-1 accepted -> WRITE next cycle.
//   - WRITE: byte_ready_o=0; wr_en_o=1 for exactly one cycle with wr_addr_o/wr_data_o
//     stable that cycle; then address += 1 (MEM_SIZE-1 wraps to 0), remaining -= 1.
//     remaining reaches 0 -> DONE (or CHECK if enabled), else COLLECT.
//   - Throughput: one word per BPW+1 cycles at full byte rate.
//   - DONE: done_o=1 one cycle, error_o valid same cycle, then IDLE (busy_o=0).
//   - wr_addr_o/wr_data_o hold last values outside WRITE; consumers use wr_en_o only.
//   - Byte stalls (byte_valid_i=0) hold state indefinitely; no timeout.
// CONFIGURATION
//   PALETTE_WRITER_CHECKSUM_EN defined:
//     8-bit modulo-256 sum of all payload bytes; after last word enter CHECK,
//     byte_ready_o=1, accept one extra byte; error_o=1 in DONE if it != sum.
//     Sum cleared on start_i. count_i==0 still expects checksum byte (0x00).
//   Not defined: no CHECK state, no extra byte, error_o tied 0.
// TESTING
//   - reset mid-COLLECT after 2 bytes -> outputs 0, busy_o=0, no wr_en_o; fresh load works.
//   - start addr 0x010 count 2, bytes 11 22 33 44 55 66 -> writes 0x10<=0x32211,
//     0x11<=0x65544 (top nibble of byte 2 dropped), done_o pulse, busy_o falls.
//   - start addr 0xFFF count 2 -> writes at 0xFFF then 0x000 (wrap).
//   - count 0 -> done_o within 2 cycles, zero wr_en_o pulses.
//   - byte_valid_i toggled randomly, start_i pulsed while busy -> same RAM image,
//     second start ignored, exactly count wr_en_o pulses.
//   - CHECKSUM_EN: bytes 01 02 03 + chk 06 -> error_o=0; chk 07 -> error_o=1 with done_o.

Source files
------------

// File: rtl/palette_writer_if.sv
// ---------------------------------------------------------------------------
// palette_writer_if
//   Bundles the load-control, byte-stream and RAM-write signals of the
//   palette writer so the writer and its host attach with a single port.
//
//   Parameters
//     ADDR_SIZE  width of the address and count fields
//     WORD_SIZE  width of one RAM word
//
//   Signals (direction as seen by the writer)
//     start_i       in   begin-load pulse
//     start_addr_i  in   first word address
//     count_i       in   number of words to load
//     byte_i        in   stream byte
//     byte_valid_i  in   stream byte valid
//     byte_ready_o  out  writer accepts a byte this cycle
//     wr_en_o       out  RAM write strobe
//     wr_addr_o     out  RAM write address
//     wr_data_o     out  RAM write data
//     busy_o        out  load in progress
//     done_o        out  end-of-load pulse
//     error_o       out  checksum mismatch, valid with done_o
//
//   Modports
//     master  host / byte source side
//     slave   palette writer side
// ---------------------------------------------------------------------------
interface palette_writer_if #(
    parameter int ADDR_SIZE = 16,
    parameter int WORD_SIZE = 20
);
    logic                 start_i;
    logic [ADDR_SIZE-1:0] start_addr_i;
    logic [ADDR_SIZE-1:0] count_i;
    logic [7:0]           byte_i;
    logic                 byte_valid_i;
    logic                 byte_ready_o;
    logic                 wr_en_o;
    logic [ADDR_SIZE-1:0] wr_addr_o;
    logic [WORD_SIZE-1:0] wr_data_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 error_o;

    modport master (
        output start_i, start_addr_i, count_i, byte_i, byte_valid_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, error_o
    );

    modport slave (
        input  start_i, start_addr_i, count_i, byte_i, byte_valid_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/palette_writer.sv
// ---------------------------------------------------------------------------
// palette_writer
//   Loads WORD_SIZE-bit words into a palette RAM from a byte stream. Bytes
//   are packed little-endian (byte k -> bits [8k+7:8k], surplus top bits
//   dropped) and each finished word is written in a single cycle at an
//   auto-incrementing address that wraps at MEM_SIZE-1.
//
//   Ports
//     clk    system clock, all state on rising edge
//     reset  asynchronous, active-high reset
//     bus    palette_writer_if.slave (load control, byte stream, RAM write)
//
//   Parameters
//     MEM_SIZE   words in the target memory
//     WORD_SIZE  bits per memory word
//     ADDR_SIZE  width of address and count fields
//
//   Optional feature (macro PALETTE_WRITER_CHECKSUM_EN)
//     When defined, a modulo-256 sum of every payload byte is kept and one
//     extra checksum byte is taken after the last word; error_o reports a
//     mismatch together with done_o. When undefined error_o is always 0.
// ---------------------------------------------------------------------------
module palette_writer #(
    parameter int MEM_SIZE  = 4096,
    parameter int WORD_SIZE = 20,
    parameter int ADDR_SIZE = 16
) (
    input  logic             clk,
    input  logic             reset,
    palette_writer_if.slave  bus
);
    localparam int BPW  = (WORD_SIZE + 7) / 8;
    localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDXW-1:0]      LAST_IDX = IDXW'(BPW - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);

`ifdef PALETTE_WRITER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_COLLECT, ST_WRITE, ST_CHECK, ST_DONE} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_COLLECT, ST_WRITE, ST_DONE} state_t;
`endif

    state_t               state;
    state_t               state_next;
    state_t               end_state;
    logic                 byte_ready;
    logic [ADDR_SIZE-1:0] addr;
    logic [ADDR_SIZE-1:0] remaining;
    logic [IDXW-1:0]      byte_idx;
    logic [BPW*8-1:0]     assembly;
    logic [BPW*8-1:0]     assembly_next;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0] wr_data;
`ifdef PALETTE_WRITER_CHECKSUM_EN
    logic [7:0]           sum;
    logic                 chk_err;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic. After the last word the load ends either in the
    // checksum byte phase or directly in DONE, depending on the build.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
`ifdef PALETTE_WRITER_CHECKSUM_EN
        end_state  = ST_CHECK;
`else
        end_state  = ST_DONE;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start_i)
                    state_next = (bus.count_i == '0) ? end_state : ST_COLLECT;
            end
            ST_COLLECT: begin
                byte_ready = 1'b1;
                if (bus.byte_valid_i && byte_idx == LAST_IDX)
                    state_next = ST_WRITE;
            end
            ST_WRITE: begin
                state_next = (remaining == ADDR_SIZE'(1)) ? end_state : ST_COLLECT;
            end
`ifdef PALETTE_WRITER_CHECKSUM_EN
            ST_CHECK: begin
                byte_ready = 1'b1;
                if (bus.byte_valid_i)
                    state_next = ST_DONE;
            end
`endif
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Drop the incoming byte into its lane of the word being assembled.
    always_comb begin
        assembly_next = assembly;
        for (int k = 0; k < BPW; k++) begin
            if (byte_idx == IDXW'(k))
                assembly_next[8*k +: 8] = bus.byte_i;
        end
    end

    // Datapath. The write address/data registers are loaded as the last
    // byte of a word arrives, so they are valid throughout WRITE and then
    // simply hold their value until the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            assembly  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
`ifdef PALETTE_WRITER_CHECKSUM_EN
            sum       <= '0;
            chk_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        addr      <= bus.start_addr_i % ADDR_SIZE'(MEM_SIZE);
                        remaining <= bus.count_i;
                        byte_idx  <= '0;
`ifdef PALETTE_WRITER_CHECKSUM_EN
                        sum       <= '0;
                        chk_err   <= 1'b0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (bus.byte_valid_i) begin
                        assembly <= assembly_next;
`ifdef PALETTE_WRITER_CHECKSUM_EN
                        sum      <= sum + bus.byte_i;
`endif
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            wr_addr  <= addr;
                            wr_data  <= assembly_next[WORD_SIZE-1:0];
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
`ifdef PALETTE_WRITER_CHECKSUM_EN
                ST_CHECK: begin
                    if (bus.byte_valid_i)
                        chk_err <= (bus.byte_i != sum);
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.byte_ready_o = byte_ready;
    assign bus.wr_en_o      = (state == ST_WRITE);
    assign bus.wr_addr_o    = wr_addr;
    assign bus.wr_data_o    = wr_data;
    assign bus.busy_o       = (state != ST_IDLE);
    assign bus.done_o       = (state == ST_DONE);
`ifdef PALETTE_WRITER_CHECKSUM_EN
    assign bus.error_o      = (state == ST_DONE) && chk_err;
`else
    assign bus.error_o      = 1'b0;
`endif
endmodule

// File: tb/tb_palette_writer.sv
// ---------------------------------------------------------------------------
// tb_palette_writer
//   Scoreboard bench for palette_writer. Stimulus pushes the hand-computed
//   RAM writes and the expected error_o for each load into queues; a monitor
//   pops and compares whenever wr_en_o or done_o is seen. Checksum bytes and
//   the checksum-error case are only exercised when
//   PALETTE_WRITER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_palette_writer;
    localparam int MEM_SIZE  = 4096;
    localparam int WORD_SIZE = 20;
    localparam int ADDR_SIZE = 16;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    palette_writer_if #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) bus ();

    palette_writer #(
        .MEM_SIZE (MEM_SIZE),
        .WORD_SIZE(WORD_SIZE),
        .ADDR_SIZE(ADDR_SIZE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    wr_t        exp_wr[$];
    logic       exp_err[$];
    logic [7:0] stim_bytes[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_count = 0;
    int last_done_cycle = 0;
    int start_cycle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison; every failure prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe and done pulse.
    initial begin
        wr_t e;
        logic ee;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                if (bus.wr_en_o === 1'b1) begin
                    wr_count++;
                    if (exp_wr.size() == 0) begin
                        checkOutput("unexpected write", 32'd1, 32'd0);
                    end else begin
                        e = exp_wr.pop_front();
                        checkOutput("write addr", 32'(bus.wr_addr_o), 32'(e.addr));
                        checkOutput("write data", 32'(bus.wr_data_o), 32'(e.data));
                    end
                end
                if (bus.done_o === 1'b1) begin
                    done_count++;
                    last_done_cycle = cyc;
                    if (exp_err.size() == 0) begin
                        checkOutput("unexpected done", 32'd1, 32'd0);
                    end else begin
                        ee = exp_err.pop_front();
                        checkOutput("done error_o", 32'(bus.error_o), 32'(ee));
                    end
                end
            end
        end
    end

    task automatic startLoad(input logic [ADDR_SIZE-1:0] a, input logic [ADDR_SIZE-1:0] n);
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.start_addr_i = a;
        bus.count_i      = n;
        start_cycle      = cyc;
        @(negedge clk);
        bus.start_i      = 1'b0;
    endtask

    // Offer one byte until the writer takes it; optionally with random stalls.
    task automatic sendByte(input logic [7:0] b, input bit stall);
        bit sent = 1'b0;
        for (int i = 0; i < 100 && !sent; i++) begin
            @(negedge clk);
            bus.byte_i       = b;
            bus.byte_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.byte_valid_i && bus.byte_ready_o) begin
                @(posedge clk);
                #1;
                bus.byte_valid_i = 1'b0;
                sent = 1'b1;
            end
        end
        if (!sent) begin
            bus.byte_valid_i = 1'b0;
            checkOutput("byte accept timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic waitDone(input int snap);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done_count > snap) seen = 1'b1;
        end
        if (!seen) checkOutput("done timeout", 32'd0, 32'd1);
        @(negedge clk);
        checkOutput("busy after done", 32'(bus.busy_o), 32'd0);
    endtask

    // Runs one load from stim_bytes; expected writes are queued by the caller.
    task automatic applyStimulus(input logic [ADDR_SIZE-1:0] a, input logic [ADDR_SIZE-1:0] n,
                                 input bit stall, input int pulse_after,
                                 input logic [7:0] chk, input logic exp_error);
        int snap = done_count;
        int wr_before = wr_count;
        exp_err.push_back(exp_error);
        startLoad(a, n);
        for (int i = 0; i < stim_bytes.size(); i++) begin
            sendByte(stim_bytes[i], stall);
            if (i == pulse_after) begin
                @(negedge clk);
                bus.start_i      = 1'b1;
                bus.start_addr_i = 16'h0300;
                bus.count_i      = 16'd5;
                @(negedge clk);
                bus.start_i      = 1'b0;
            end
        end
`ifdef PALETTE_WRITER_CHECKSUM_EN
        sendByte(chk, stall);
`else
        if (chk != 8'h00 && exp_error) $display("[TB] note: checksum byte unused");
`endif
        waitDone(snap);
        checkOutput("write pulse count", 32'(wr_count - wr_before), 32'(n));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " busy_o"},       32'(bus.busy_o),       32'd0);
        checkOutput({tag, " wr_en_o"},      32'(bus.wr_en_o),      32'd0);
        checkOutput({tag, " done_o"},       32'(bus.done_o),       32'd0);
        checkOutput({tag, " error_o"},      32'(bus.error_o),      32'd0);
        checkOutput({tag, " byte_ready_o"}, 32'(bus.byte_ready_o), 32'd0);
        checkOutput({tag, " wr_addr_o"},    32'(bus.wr_addr_o),    32'd0);
        checkOutput({tag, " wr_data_o"},    32'(bus.wr_data_o),    32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.start_i      = 1'b0;
        bus.start_addr_i = '0;
        bus.count_i      = '0;
        bus.byte_i       = '0;
        bus.byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;

        // Basic two-word load; top nibble of byte 2 is dropped.
        stim_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_wr.push_back('{16'h0010, 20'h32211});
        exp_wr.push_back('{16'h0011, 20'h65544});
        applyStimulus(16'h0010, 16'd2, 1'b0, -1, 8'h65, 1'b0);

        // Address wrap at MEM_SIZE-1.
        stim_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02, 8'h03};
        exp_wr.push_back('{16'h0FFF, 20'hCBBAA});
        exp_wr.push_back('{16'h0000, 20'h30201});
        applyStimulus(16'h0FFF, 16'd2, 1'b0, -1, 8'h37, 1'b0);

        // Zero-length load.
        stim_bytes = {};
        applyStimulus(16'h0123, 16'd0, 1'b0, -1, 8'h00, 1'b0);
`ifndef PALETTE_WRITER_CHECKSUM_EN
        checkOutput("count0 done latency", 32'((last_done_cycle - start_cycle) <= 2), 32'd1);
`endif

        // Random stalls, out-of-range start address, start pulsed while busy.
        stim_bytes = '{8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'hF0, 8'hFF, 8'h7E};
        exp_wr.push_back('{16'h0005, 20'h30201});
        exp_wr.push_back('{16'h0006, 20'hC0B0A});
        exp_wr.push_back('{16'h0007, 20'hEFFF0});
        applyStimulus(16'h1005, 16'd3, 1'b1, 1, 8'h94, 1'b0);

        // Reset in the middle of a word: nothing written, outputs cleared.
        startLoad(16'h0020, 16'd1);
        sendByte(8'h5A, 1'b0);
        sendByte(8'hA5, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkIdleOutputs("mid reset");
        @(negedge clk);
        reset = 1'b0;

        // Fresh load after the abandoned one.
        stim_bytes = '{8'h5A, 8'hA5, 8'h3C};
        exp_wr.push_back('{16'h0020, 20'hCA55A});
        applyStimulus(16'h0020, 16'd1, 1'b0, -1, 8'h3B, 1'b0);

`ifdef PALETTE_WRITER_CHECKSUM_EN
        stim_bytes = '{8'h01, 8'h02, 8'h03};
        exp_wr.push_back('{16'h0040, 20'h30201});
        applyStimulus(16'h0040, 16'd1, 1'b0, -1, 8'h06, 1'b0);
        exp_wr.push_back('{16'h0040, 20'h30201});
        applyStimulus(16'h0040, 16'd1, 1'b0, -1, 8'h07, 1'b1);
`endif

        repeat (4) @(negedge clk);
        checkOutput("pending writes", 32'(exp_wr.size()), 32'd0);
        checkOutput("pending dones", 32'(exp_err.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
